// File: rtl/sent_tx_scheduler.sv
// Round-robin arbiter sharing one SENT transmit controller among four requesters.
// Latches the winner's channel config, strobes the controller, and guards start/busy hangs.
module sent_tx_scheduler #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned START_WAIT     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_tx,
  input  logic        reset_n_tx,
  input  logic        enable_i,
  input  logic [3:0]  req_i,
  input  logic [7:0]  req_fmt_i,
  input  logic [3:0]  req_pause_i,
  input  logic [3:0]  req_cfg_i,
  input  logic [31:0] req_id_i,
  input  logic [63:0] req_data_i,
  input  logic        tx_ready_i,
  output logic [3:0]  grant_o,
  output logic [3:0]  done_o,
  output logic        tx_enable_o,
  output logic [1:0]  tx_channel_format_o,
  output logic        tx_optional_pause_o,
  output logic        tx_config_bit_o,
  output logic [7:0]  tx_id_o,
  output logic [15:0] tx_data_bit_field_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 16;
  localparam logic [CW-1:0] START_LAST   = CW'((START_WAIT > 0) ? START_WAIT - 1 : 0);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, BUSY, GAP} state_t;

  state_t        state, state_d;
  logic [1:0]    ptr, ptr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    grant_d, done_d;
  logic          tx_enable_d, err_d, abort;
  logic [7:0]    err_cnt_d;
  logic          load;
  logic          found;
  logic [1:0]    winner, idx;

  // Round-robin search starting at ptr
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    cnt_d       = cnt;
    grant_d     = grant_o;
    done_d      = '0;
    tx_enable_d = 1'b0;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_o;
    load        = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i && found && tx_ready_i) begin
          grant_d     = 4'b0001 << winner;
          load        = 1'b1;
          tx_enable_d = 1'b1;
          ptr_d       = winner + 2'd1;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!tx_ready_i) begin
          cnt_d   = '0;
          state_d = BUSY;
        end else if (cnt >= START_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      BUSY: begin
        // completion takes priority over a coincident timeout
        if (tx_ready_i) begin
          done_d  = grant_o;
          grant_d = '0;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt >= TIMEOUT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt >= GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      err_d   = 1'b1;
      grant_d = '0;
      cnt_d   = '0;
      state_d = GAP;
      if (err_cnt_o != 8'hFF) err_cnt_d = err_cnt_o + 8'd1;
    end
  end

  // State and control registers
  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant_o     <= '0;
      done_o      <= '0;
      tx_enable_o <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      cnt         <= cnt_d;
      grant_o     <= grant_d;
      done_o      <= done_d;
      tx_enable_o <= tx_enable_d;
      busy_o      <= (state_d != IDLE);
      err_o       <= err_d;
      err_cnt_o   <= err_cnt_d;
    end
  end

  // Channel configuration, captured only at the grant edge
  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      tx_channel_format_o <= '0;
      tx_optional_pause_o <= 1'b0;
      tx_config_bit_o     <= 1'b0;
      tx_id_o             <= '0;
      tx_data_bit_field_o <= '0;
    end else if (load) begin
      tx_channel_format_o <= req_fmt_i[{winner, 1'b0} +: 2];
      tx_optional_pause_o <= req_pause_i[winner];
      tx_config_bit_o     <= req_cfg_i[winner];
      tx_id_o             <= req_id_i[{winner, 3'b000} +: 8];
      tx_data_bit_field_o <= req_data_i[{winner, 4'b0000} +: 16];
    end
  end

endmodule

// File: tb/tb_sent_tx_scheduler.sv
// Directed bench for sent_tx_scheduler: grant timing, round-robin order, gap,
// start/busy timeouts, error saturation and asynchronous reset.
module tb_sent_tx_scheduler;

  logic        clk_tx = 1'b0;
  logic        reset_n_tx;
  logic        enable_i;
  logic [3:0]  req_i;
  logic [7:0]  req_fmt_i;
  logic [3:0]  req_pause_i;
  logic [3:0]  req_cfg_i;
  logic [31:0] req_id_i;
  logic [63:0] req_data_i;
  logic        tx_ready_i;
  logic [3:0]  grant_o;
  logic [3:0]  done_o;
  logic        tx_enable_o;
  logic [1:0]  tx_channel_format_o;
  logic        tx_optional_pause_o;
  logic        tx_config_bit_o;
  logic [7:0]  tx_id_o;
  logic [15:0] tx_data_bit_field_o;
  logic        busy_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  sent_tx_scheduler #(
    .GAP_CYCLES(2), .START_WAIT(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_tx(clk_tx), .reset_n_tx(reset_n_tx), .enable_i(enable_i), .req_i(req_i),
    .req_fmt_i(req_fmt_i), .req_pause_i(req_pause_i), .req_cfg_i(req_cfg_i),
    .req_id_i(req_id_i), .req_data_i(req_data_i), .tx_ready_i(tx_ready_i),
    .grant_o(grant_o), .done_o(done_o), .tx_enable_o(tx_enable_o),
    .tx_channel_format_o(tx_channel_format_o), .tx_optional_pause_o(tx_optional_pause_o),
    .tx_config_bit_o(tx_config_bit_o), .tx_id_o(tx_id_o),
    .tx_data_bit_field_o(tx_data_bit_field_o), .busy_o(busy_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk_tx = ~clk_tx;

  task automatic step();
    @(posedge clk_tx);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Step until the start strobe appears, then check the grant that came with it
  task automatic wait_enable(input logic [3:0] exp, input string tag);
    int n = 0;
    while (tx_enable_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk(tag, 32'({tx_enable_o, grant_o}), 32'({1'b1, exp}));
  endtask

  // Controller model: drop ready during the transfer, raise it and expect done
  task automatic finish_txn(input logic [3:0] exp, input string tag);
    int n = 0;
    tx_ready_i = 1'b0;
    repeat (3) step();
    tx_ready_i = 1'b1;
    step();
    while (done_o === 4'b0000 && n < 10) begin
      step();
      n++;
    end
    chk(tag, 32'(done_o), 32'(exp));
  endtask

  initial begin
    int n;
    logic saw_done;
    reset_n_tx  = 1'b0;
    enable_i    = 1'b0;
    req_i       = '0;
    req_fmt_i   = 8'b10_01_00_00;
    req_pause_i = 4'b0001;
    req_cfg_i   = 4'b0001;
    req_id_i    = 32'h13_12_11_05;
    req_data_i  = 64'h3333_2222_1111_00A5;
    tx_ready_i  = 1'b1;
    step();
    step();
    chk("reset_ctrl", 32'({grant_o, done_o, tx_enable_o, busy_o, err_o}), 32'(0));
    chk("reset_cfg", 32'({tx_channel_format_o, tx_optional_pause_o, tx_config_bit_o, tx_id_o}), 32'(0));
    chk("reset_data_errcnt", 32'({tx_data_bit_field_o, err_cnt_o}), 32'(0));

    reset_n_tx = 1'b1;
    req_i = 4'b0001;
    repeat (4) step();
    chk("disabled_no_grant", 32'({grant_o, tx_enable_o, busy_o}), 32'(0));

    // Single request from requester 0
    enable_i = 1'b1;
    step();
    chk("single_grant", 32'({grant_o, tx_enable_o, busy_o}), 32'({4'b0001, 1'b1, 1'b1}));
    chk("single_cfg", 32'({tx_channel_format_o, tx_optional_pause_o, tx_config_bit_o, tx_id_o}),
        32'({2'b00, 1'b1, 1'b1, 8'h05}));
    chk("single_data", 32'(tx_data_bit_field_o), 32'(16'h00A5));
    req_i = 4'b0000;
    tx_ready_i = 1'b0;
    step();
    chk("strobe_one_cycle", 32'({tx_enable_o, grant_o}), 32'({1'b0, 4'b0001}));
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) req_data_i[15:0] = 16'hFFFF;
      step();
      if (done_o !== 4'b0000) saw_done = 1'b1;
    end
    chk("no_early_done", 32'(saw_done), 32'(0));
    chk("cfg_stable_busy", 32'(tx_data_bit_field_o), 32'(16'h00A5));
    tx_ready_i = 1'b1;
    step();
    chk("single_done", 32'({done_o, grant_o, err_o}), 32'({4'b0001, 4'b0000, 1'b0}));
    req_i = 4'b0010;
    step();
    chk("done_one_cycle", 32'({done_o, grant_o}), 32'(0));
    step();
    step();
    chk("gap_hold", 32'({grant_o, tx_enable_o}), 32'(0));
    chk("cfg_stable_gap", 32'(tx_data_bit_field_o), 32'(16'h00A5));
    step();
    chk("gap_regrant", 32'({grant_o, tx_enable_o, tx_id_o}), 32'({4'b0010, 1'b1, 8'h11}));
    req_i = 4'b1111;
    finish_txn(4'b0010, "done_r1");

    // Round-robin with every requester asking; pointer now at 2
    wait_enable(4'b0100, "rr_grant2");
    chk("rr_fmt2", 32'(tx_channel_format_o), 32'(2'b01));
    finish_txn(4'b0100, "rr_done2");
    wait_enable(4'b1000, "rr_grant3");
    chk("rr_fast_cfg3", 32'({tx_channel_format_o, tx_id_o, tx_data_bit_field_o}),
        32'({2'b10, 8'h13, 16'h3333}));
    finish_txn(4'b1000, "rr_done3");
    wait_enable(4'b0001, "rr_wrap0");
    chk("rr_new_data0", 32'(tx_data_bit_field_o), 32'(16'hFFFF));
    finish_txn(4'b0001, "rr_done0");
    wait_enable(4'b0010, "rr_grant1");
    finish_txn(4'b0010, "rr_done1");
    wait_enable(4'b0100, "rr_grant2b");
    req_i = 4'b0000;
    finish_txn(4'b0100, "rr_done2b");

    // Start timeout: ready never falls; pointer now at 3
    req_i = 4'b0001;
    wait_enable(4'b0001, "st_grant");
    repeat (4) step();
    chk("st_no_early_err", 32'(err_o), 32'(0));
    step();
    chk("st_err", 32'({err_o, err_cnt_o, done_o, grant_o}), 32'({1'b1, 8'd1, 4'b0000, 4'b0000}));
    repeat (4) step();
    chk("st_rearb", 32'({tx_enable_o, grant_o}), 32'({1'b1, 4'b0001}));

    // Busy timeout: ready stays low for the full 100 busy cycles
    tx_ready_i = 1'b0;
    req_i = 4'b0000;
    repeat (101) step();
    chk("bt_no_early_err", 32'({err_o, grant_o}), 32'({1'b0, 4'b0001}));
    step();
    chk("bt_err", 32'({err_o, err_cnt_o, done_o, grant_o}), 32'({1'b1, 8'd2, 4'b0000, 4'b0000}));
    tx_ready_i = 1'b1;
    step();
    chk("bt_no_done", 32'({done_o, err_o}), 32'(0));

    // Ready returns exactly on the timeout cycle: completion wins
    req_i = 4'b0010;
    wait_enable(4'b0010, "sim_grant");
    tx_ready_i = 1'b0;
    req_i = 4'b0000;
    repeat (101) step();
    tx_ready_i = 1'b1;
    step();
    chk("sim_done", 32'({done_o, err_o, err_cnt_o}), 32'({4'b0010, 1'b0, 8'd2}));

    // Error counter saturation via repeated start timeouts
    req_i = 4'b0001;
    n = 0;
    while (err_cnt_o !== 8'd255 && n < 6000) begin
      step();
      n++;
    end
    chk("sat_reach", 32'(err_cnt_o), 32'(255));
    step();
    n = 0;
    while (err_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("sat_pulse", 32'({err_o, err_cnt_o}), 32'({1'b1, 8'd255}));

    // Asynchronous reset in the middle of a transfer
    req_i = 4'b0100;
    wait_enable(4'b0100, "rst_grant");
    tx_ready_i = 1'b0;
    req_i = 4'b0000;
    repeat (5) step();
    reset_n_tx = 1'b0;
    #1;
    chk("rst_async", 32'({grant_o, busy_o, err_cnt_o, tx_id_o}), 32'(0));
    step();
    chk("rst_no_done", 32'({done_o, grant_o}), 32'(0));
    reset_n_tx = 1'b1;
    tx_ready_i = 1'b1;
    req_i = 4'b1111;
    wait_enable(4'b0001, "rst_ptr_zero");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sent_tx_scheduler.md
# sent_tx_scheduler

Round-robin scheduler that shares the single SENT transmit controller between four message requesters. It latches the winning requester's channel configuration and holds it stable for the whole transmission. It issues a one-cycle start strobe and tracks completion through the controller's ready flag. It also enforces an inter-message gap and flags controllers that hang.

## Interface

Parameters:
- GAP_CYCLES, 2, idle cycles inserted after each completed or aborted message (0 allowed)
- START_WAIT, 4, max cycles to see tx_ready_i fall after the start strobe
- TIMEOUT_CYCLES, 65535, max cycles in BUSY before a timeout error (16-bit counter)

Ports:
- clk_tx  in  1  clock; the single clock, all logic on its rising edge
- reset_n_tx  in  1  asynchronous, active-low reset
- enable_i  in  1  global scheduler enable; gates new arbitration only
- req_i  in  4  level request per requester k
- req_fmt_i  in  8  channel format per requester, [2k+1:2k]: 00 serial, 01 enhanced, 10 fast
- req_pause_i  in  4  optional-pause select per requester
- req_cfg_i  in  4  enhanced config bit per requester
- req_id_i  in  32  message ID per requester, [8k+7:8k]
- req_data_i  in  64  data bit field per requester, [16k+15:16k]
- tx_ready_i  in  1  controller ready (high only when the controller is idle)
- grant_o  out  4  one-hot grant, held from launch until completion
- done_o  out  4  one-cycle completion pulse for the granted requester
- tx_enable_o  out  1  one-cycle start strobe to the controller
- tx_channel_format_o  out  2  latched format
- tx_optional_pause_o  out  1  latched pause select
- tx_config_bit_o  out  1  latched config bit
- tx_id_o  out  8  latched ID
- tx_data_bit_field_o  out  16  latched data field
- busy_o  out  1  high in every state except IDLE
- err_o  out  1  one-cycle pulse on start or busy timeout
- err_cnt_o  out  8  saturating error count (stops at 255)

## Operation

- States: IDLE, LAUNCH, WAIT_START, BUSY, GAP.
- IDLE:
  - When enable_i=1, at least one req_i bit is set, and tx_ready_i=1, pick the winner by round-robin.
  - Search order is ptr, ptr+1, ... mod 4.
  - Set grant_o to one-hot(winner).
  - Latch the winner's fmt, pause, cfg, id, and data into the tx_*_o registers.
  - Set tx_enable_o=1 and go to LAUNCH.
  - Update ptr to (winner+1) mod 4.
- LAUNCH: clear tx_enable_o, clear the wait counter, go to WAIT_START.
- WAIT_START:
  - On tx_ready_i=0, clear the busy counter and go to BUSY.
  - If START_WAIT cycles elapse without that, pulse err_o, increment err_cnt_o, clear grant_o, and go to GAP. No done_o is issued.
- BUSY:
  - On tx_ready_i=1, pulse done_o[winner], clear grant_o, and go to GAP.
  - If the busy counter reaches TIMEOUT_CYCLES, pulse err_o, increment err_cnt_o, clear grant_o, and go to GAP.
- GAP: count GAP_CYCLES, then go to IDLE. With GAP_CYCLES=0, stay exactly one cycle in GAP.
- The tx_*_o configuration registers change only at the grant edge. They hold their values through BUSY, GAP, and IDLE until the next grant.
- Requests are level-sensitive.
  - A requester whose req_i drops after grant still completes its transmission.
  - A new or held request is considered only in IDLE.
- enable_i=0 during LAUNCH, WAIT_START, BUSY, or GAP does not abort the transmission. It only blocks the next arbitration.
- Fast-format (10) requests need no serial/enhanced bookkeeping. They are scheduled identically to other formats.

## Timing

- Reset (asynchronous): state IDLE, ptr=0, and all outputs zero (grant_o, done_o, tx_*_o, busy_o, err_o, err_cnt_o). A reset mid-message drops grant_o immediately and issues no done_o.
- Grant latency: if the request conditions hold in cycle C, then grant_o, tx_enable_o, and the config registers are valid from cycle C+1.
- tx_enable_o is high for exactly one cycle per grant.
- done_o is asserted in the cycle after tx_ready_i returning high is sampled in BUSY. grant_o falls in that same cycle.
- Minimum spacing from done_o to the next tx_enable_o is GAP_CYCLES+2 cycles.
- Simultaneous timeout and tx_ready_i=1 in BUSY: completion wins, so done_o fires and err_o does not.
- Error counter at 255: err_o still pulses, err_cnt_o holds at 255.
- ptr wrap: after a grant to requester 3, ptr=0.

## Test plan

- Single request: req_i=0001, fmt=00, id=0x05, data=0x00A5, with a controller model that drops ready 1 cycle after enable and raises it 40 cycles later. Expect grant_o=0001 and a 1-cycle tx_enable_o one cycle after the request, tx_id_o=0x05, then done_o=0001 and GAP_CYCLES idle cycles.
- Round-robin: req_i=1111 held through four transactions. Expect the grant order 0001, 0010, 0100, 1000, then 0001 again, with ptr wrapping.
- Config stability: change req_data_i[15:0] while BUSY. Expect tx_data_bit_field_o unchanged until the next grant.
- Start timeout: tx_ready_i stuck at 1 with START_WAIT=4. Expect err_o pulse 5 cycles after the strobe, err_cnt_o=1, no done_o, and re-arbitration after GAP.
- Busy timeout with TIMEOUT_CYCLES=100, plus a simultaneous-edge case where ready rises on cycle 100. Expect err_o in the timeout case; expect done_o only in the simultaneous case.
- Asserting reset_n_tx low mid-BUSY clears all outputs immediately. enable_i=0 with req_i pending yields no grant.
